frame_uart_tx: RTL and testbench
================================

Name: frame_uart_tx

Overview:
Parametrised serial frame transmitter for the board-state link.
- Latches a PAYLOAD_W-bit word on trigger_in.
- Sends it on a single wire as ceil(PAYLOAD_W/8) UART characters, LSB first, with a programmable bit period and optional inter-character gap.
- Sits between the game-state logic and the board-to-board serial pin; the existing rx side consumes its output.

Parameters:
- PAYLOAD_W, 162, payload width in bits (>=1).
- CLKS_PER_BIT, 868, clock cycles per serial bit (>=2).
- INTER_CHAR_GAP, 0, idle-high bit periods inserted between characters; never after the last character.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- trigger_in  input  1  start request; accepted only when busy_out==0
- val_in  input  PAYLOAD_W  payload, sampled on the accepting edge
- data_out  output  1  serial line, idle high
- busy_out  output  1  high from the accepting edge until the frame completes
- done_out  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, any time): data_out=1, busy_out=0, done_out=0, state IDLE, counters cleared, frame aborted immediately.
- NUM_CHARS = ceil(PAYLOAD_W/8).
  - Payload is zero-extended to NUM_CHARS*8 bits.
  - Char k carries bits [8k+7:8k], sent bit 0 first.
- Char format: start bit (0), 8 data bits, [parity], stop bit (1). Every bit is held exactly CLKS_PER_BIT cycles.
- Accept: trigger_in=1 and busy_out=0 at edge N.
  - At edge N: payload is loaded into the shift register, busy_out=1, FSM enters START.
  - data_out=0 is visible from edge N onward (registered output, latency 1).
- trigger_in while busy_out=1 is ignored; no queuing.
- val_in changes after the accepting edge have no effect.
- FSM sequence: IDLE -> START -> DATA (8 bits) -> [PARITY] -> STOP.
  - After STOP: if chars remain, go to GAP (INTER_CHAR_GAP bit periods, data_out=1; skipped if 0), then START.
  - After STOP of the last char: go to IDLE.
- Completion, at the edge ending the last stop bit:
  - busy_out=0 and done_out=1 for exactly one cycle.
  - data_out stays 1.
- Back-to-back: trigger_in in the done_out cycle is accepted, since busy_out is already 0. The next start bit immediately follows the stop bit with no extra idle time.
- Frame length in cycles = NUM_CHARS*B*CLKS_PER_BIT + (NUM_CHARS-1)*INTER_CHAR_GAP*CLKS_PER_BIT, where B = 10, or 11 with parity.
- Counter widths:
  - bit-period counter: $clog2(CLKS_PER_BIT)
  - char counter: $clog2(NUM_CHARS+1)
  - no wrap-around within a frame.
- data_out is driven from a flop only (glitch-free).

Optional Feature:
- Macro: FRAME_UART_TX_PARITY_EN
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit; B=11.
- Undefined: no parity state; B=10.

Decomposition:
- Package frame_uart_pkg:
  - CHAR_W=8
  - state enum {IDLE, START, DATA, PARITY, STOP, GAP}
  - function num_chars(payload_w)
- Sub-module baud_tick_gen (parameter CLKS_PER_BIT):
  - restartable counter emitting a one-cycle bit_tick at the end of each bit period
  - restarted on frame accept.

Test Plan:
- Test parameters: PAYLOAD_W=162, CLKS_PER_BIT=4, gap 0, val_in=162'h2_AAAA…AAAA; reset pulse, then trigger.
  - Expect 21 chars: chars 0..19 = 0xAA, char 20 = 0x02.
  - busy_out high for 840 cycles, then a single done_out pulse.
- Same setup with FRAME_UART_TX_PARITY_EN defined:
  - parity bit 0 for 0xAA, 1 for 0x02.
  - Frame length 924 cycles.
- INTER_CHAR_GAP=1:
  - data_out high for 4 cycles between each pair of stop/start bits.
  - Frame length 920 cycles; no gap after char 20.
- Trigger pulsed at cycle 100 of a frame:
  - ignored; frame content and length unchanged.
- Trigger asserted during the done_out cycle:
  - second frame accepted; its start bit begins at the very next cycle.
- rst_in asserted mid-char (cycle 300):
  - data_out=1, busy_out=0 asynchronously, with no done_out pulse.
  - A subsequent trigger sends a complete, correct frame.

Source files
------------

// File: rtl/frame_uart_pkg.sv
// Shared types and helpers for the frame UART transmitter.
package frame_uart_pkg;

  localparam int CHAR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } state_e;

  // Number of 8-bit characters needed to carry a payload of the given width.
  function automatic int num_chars(input int payload_w);
    return (payload_w + CHAR_W - 1) / CHAR_W;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: pulses bit_tick on the last cycle of every bit period.
// restart re-aligns the period to the cycle after the restarting edge.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic restart,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Period counter: cleared on restart, wraps at the end of each bit period.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/frame_uart_tx.sv
// Serial frame transmitter: sends a latched PAYLOAD_W-bit word as
// ceil(PAYLOAD_W/8) UART characters, LSB first, idle-high line.
// Optional build macro FRAME_UART_TX_PARITY_EN adds an even-parity bit per char.
module frame_uart_tx
  import frame_uart_pkg::*;
#(
  parameter int PAYLOAD_W      = 162,
  parameter int CLKS_PER_BIT   = 868,
  parameter int INTER_CHAR_GAP = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 trigger_in,
  input  logic [PAYLOAD_W-1:0] val_in,
  output logic                 data_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int NUM_CHARS = num_chars(PAYLOAD_W);
  localparam int SR_W      = NUM_CHARS * CHAR_W;
  localparam int CCNT_W    = $clog2(NUM_CHARS + 1);
  localparam int GAP_W     = (INTER_CHAR_GAP > 1) ? $clog2(INTER_CHAR_GAP) : 1;
  localparam logic [CCNT_W-1:0] CHAR_LAST = CCNT_W'(NUM_CHARS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((INTER_CHAR_GAP > 0) ? INTER_CHAR_GAP - 1 : 0);

  state_e              state_q, state_d;
  logic [SR_W-1:0]     sreg_q, sreg_d;
  logic [2:0]          bit_q, bit_d;
  logic [CCNT_W-1:0]   char_q, char_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                restart;
  logic                bit_tick;
`ifdef FRAME_UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .restart (restart),
    .enable  (busy_q),
    .bit_tick(bit_tick)
  );

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: the shift register is reset along with control so a single reset domain covers the whole block.
    if (rst_in) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      gap_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FRAME_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FRAME_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and next-output logic; the line value is computed one bit ahead and registered.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    char_d  = char_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    restart = 1'b0;
`ifdef FRAME_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (trigger_in && !busy_q) begin
          sreg_d  = SR_W'(val_in);
          char_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          restart = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          bit_d   = '0;
          tx_d    = sreg_q[0];
`ifdef FRAME_UART_TX_PARITY_EN
          par_d   = sreg_q[0];
`endif
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          sreg_d = sreg_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef FRAME_UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sreg_q[1];
`ifdef FRAME_UART_TX_PARITY_EN
            par_d = par_q ^ sreg_q[1];
`endif
          end
        end
      end
`ifdef FRAME_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (char_q == CHAR_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            char_d = char_q + 1'b1;
            if (INTER_CHAR_GAP > 0) begin
              gap_d   = '0;
              state_d = GAP;
            end else begin
              tx_d    = 1'b0;
              state_d = START;
            end
          end
        end
      end
      GAP: begin
        if (bit_tick) begin
          if (gap_q == GAP_LAST) begin
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out = tx_q;
  assign busy_out = busy_q;
  assign done_out = done_q;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Directed bench for frame_uart_tx: two instances (no gap / one-bit gap),
// CLKS_PER_BIT=4, PAYLOAD_W=162. Honours FRAME_UART_TX_PARITY_EN.
module tb_frame_uart_tx;

  localparam int C  = 4;
  localparam int PW = 162;
  localparam int NC = 21;
`ifdef FRAME_UART_TX_PARITY_EN
  localparam int B    = 11;
  localparam bit PAR  = 1'b1;
  localparam int LEN0 = 924;
  localparam int LEN1 = 1004;
`else
  localparam int B    = 10;
  localparam bit PAR  = 1'b0;
  localparam int LEN0 = 840;
  localparam int LEN1 = 920;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          trig, trig_g;
  logic [PW-1:0] val;
  logic          data0, busy0, done0;
  logic          data_g, busy_g, done_g;
  logic          sel_gap;
  logic          cur_data, cur_busy, cur_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic samp [0:2047];

  always #5 clk = ~clk;

  frame_uart_tx #(.PAYLOAD_W(PW), .CLKS_PER_BIT(C), .INTER_CHAR_GAP(0)) dut (
    .clk_in(clk), .rst_in(rst), .trigger_in(trig), .val_in(val),
    .data_out(data0), .busy_out(busy0), .done_out(done0)
  );

  frame_uart_tx #(.PAYLOAD_W(PW), .CLKS_PER_BIT(C), .INTER_CHAR_GAP(1)) dut_gap (
    .clk_in(clk), .rst_in(rst), .trigger_in(trig_g), .val_in(val),
    .data_out(data_g), .busy_out(busy_g), .done_out(done_g)
  );

  assign cur_data = sel_gap ? data_g : data0;
  assign cur_busy = sel_gap ? busy_g : busy0;
  assign cur_done = sel_gap ? done_g : done0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_trig(input logic v);
    if (sel_gap) trig_g = v;
    else         trig   = v;
  endtask

  // Expected line level k cycles after the accepting edge.
  function automatic logic exp_bit(input logic [167:0] p, input int gap, input int k);
    int slot, ch, off;
    logic [7:0] b;
    slot = (B + gap) * C;
    ch   = k / slot;
    off  = (k % slot) / C;
    b    = p[ch*8 +: 8];
    if (off == 0) return 1'b0;
    if (off <= 8) return b[off-1];
    if (PAR && off == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [7:0] decode(input int ch, input int slot);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = samp[ch*slot + (1+i)*C + C/2];
    return v;
  endfunction

  // Start: called on a negedge; returns on the negedge of frame cycle k=0.
  task automatic start_frame();
    set_trig(1'b1);
    @(negedge clk);
    set_trig(1'b0);
    val = ~val;
  endtask

  // Watch one frame from cycle k=0 through the done pulse and the cycle after.
  task automatic watch_frame(input string tag, input logic [PW-1:0] pay, input int gap,
                             input int len, input int pulse_at, input bit retrig,
                             input logic [PW-1:0] next_val);
    int   bad, busy_bad, first;
    logic fw, fe, e;
    logic [167:0] p;
    p = {6'b0, pay};
    bad = 0; busy_bad = 0; first = -1; fw = 1'b0; fe = 1'b0;
    for (int k = 0; k < len; k++) begin
      e = exp_bit(p, gap, k);
      samp[k] = cur_data;
      if (cur_data !== e) begin
        if (bad == 0) begin first = k; fw = cur_data; fe = e; end
        bad++;
      end
      if (cur_busy !== 1'b1 || cur_done !== 1'b0) busy_bad++;
      if (k == pulse_at) set_trig(1'b1);
      @(negedge clk);
      if (k == pulse_at) set_trig(1'b0);
    end
    check($sformatf("%s stream bad cycles (first k=%0d line %b want %b)", tag, first, fw, fe), bad, 0);
    check($sformatf("%s busy/done during frame", tag), busy_bad, 0);
    check($sformatf("%s done at end", tag), cur_done, 1);
    check($sformatf("%s busy at end", tag), cur_busy, 0);
    check($sformatf("%s line at end", tag), cur_data, 1);
    if (retrig) begin
      val = next_val;
      set_trig(1'b1);
    end
    @(negedge clk);
    if (retrig) begin
      set_trig(1'b0);
      val = ~next_val;
    end
    check($sformatf("%s done one cycle", tag), cur_done, 0);
    check($sformatf("%s busy after end", tag), cur_busy, 32'(retrig));
    check($sformatf("%s line after end", tag), cur_data, 32'(!retrig));
  endtask

  initial begin
    logic [PW-1:0] pay_a, pay_b;
    int done_seen;
    pay_a = {2'b10, {20{8'hAA}}};
    pay_b = {2'b11, 160'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C};

    rst = 1'b1; trig = 1'b0; trig_g = 1'b0; val = '0; sel_gap = 1'b0;
    repeat (2) @(negedge clk);
    check("reset line", data0, 1);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset gap line", data_g, 1);
    check("reset gap busy", busy_g, 0);
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: 0xAA x20 + 0x02, ignored trigger at cycle 100, retrigger in done cycle.
    val = pay_a;
    start_frame();
    watch_frame("f1", pay_a, 0, LEN0, 100, 1'b1, pay_b);
    check("f1 char0", decode(0, B*C), 8'hAA);
    check("f1 char19", decode(19, B*C), 8'hAA);
    check("f1 char20", decode(20, B*C), 8'h02);
`ifdef FRAME_UART_TX_PARITY_EN
    check("f1 parity char0", samp[0*B*C + 9*C + C/2], 0);
    check("f1 parity char20", samp[20*B*C + 9*C + C/2], 1);
`endif

    // Frame 2: back-to-back frame, already at its cycle k=0.
    watch_frame("f2", pay_b, 0, LEN0, -1, 1'b0, '0);
    check("f2 char0", decode(0, B*C), 8'h3C);
    check("f2 char20", decode(20, B*C), 8'h03);

    // Frame 3: one-bit-period gap between characters.
    sel_gap = 1'b1;
    @(negedge clk);
    val = pay_a;
    start_frame();
    watch_frame("gap", pay_a, 1, LEN1, -1, 1'b0, '0);
    check("gap char20", decode(20, (B+1)*C), 8'h02);
    check("gap idle slot", samp[B*C + C/2], 1);
    check("idle inst untouched", busy0, 0);
    sel_gap = 1'b0;

    // Frame 4: asynchronous reset mid-character.
    @(negedge clk);
    val = pay_b;
    start_frame();
    repeat (300) @(negedge clk);
    check("pre-reset busy", busy0, 1);
    #2 rst = 1'b1;
    #1;
    check("async rst line", data0, 1);
    check("async rst busy", busy0, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      if (done0 === 1'b1) done_seen++;
    end
    check("no done after reset", done_seen, 0);
    check("idle after reset", busy0, 0);

    // Frame 5: clean frame after reset.
    val = pay_a;
    start_frame();
    watch_frame("f5", pay_a, 0, LEN0, -1, 1'b0, '0);
    check("f5 char20", decode(20, B*C), 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
